// File: rtl/ahblite_uart_master_pkg.sv
// Shared constants and state encodings for the UART-driven AHB-Lite bus master.
// Holds the frame command/ack bytes, the HTRANS/HSIZE/HBURST/HPROT codes used on
// the bus, and the parser and transmit-serializer state enums.
package ahblite_uart_master_pkg;

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_READ  = 8'h5A;
  localparam logic [7:0] ACK_OK    = 8'h4B;
  localparam logic [7:0] ACK_ERR   = 8'h45;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StBusA,
    StBusD,
    StResp
  } state_e;

  // Per-byte transmit handshake inside the response state.
  typedef enum logic [1:0] {
    TxSend,
    TxGap,
    TxWait
  } tx_phase_e;

endpackage

// File: rtl/ahblite_uart_master_if.sv
// AHB-Lite bus bundle between a single initiator and the bus fabric.
// master modport: drives address/control/write data, receives HRDATA/HREADY/HRESP.
// slave modport: the mirror image, used by the fabric or a bus model.
interface ahblite_uart_master_if;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahblite_uart_master.sv
// UART-driven AHB-Lite bus master for boot loading and debug.
// Parses command frames from the UART receive strobe, performs one single-word
// AHB-Lite read or write, then returns the ack byte or read data over UART.
// Ports:
//   HCLK, HRESETn      clock, asynchronous active-low reset
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   tx_data, tx_en     byte to send and one-cycle transmit request (registered)
//   tx_busy            transmitter busy
//   ahb                AHB-Lite initiator port (all outputs registered)
module ahblite_uart_master
  import ahblite_uart_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   tx_data,
  output logic                         tx_en,
  input  logic                         tx_busy,
  ahblite_uart_master_if.master        ahb
);

  localparam int unsigned TimeoutWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimeoutWidth-1:0] TimeoutMax = TimeoutWidth'(TIMEOUT_CYCLES);

  state_e                  state_q, state_d;
  tx_phase_e               tx_phase_q, tx_phase_d;
  logic                    is_write_q, is_write_d;
  logic                    err_q, err_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [TimeoutWidth-1:0] tmo_q, tmo_d;
  logic [1:0]              htrans_q, htrans_d;
  logic [31:0]             haddr_q, haddr_d;
  logic                    hwrite_q, hwrite_d;
  logic [31:0]             hwdata_q, hwdata_d;
  logic                    tx_en_q, tx_en_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    last_byte;

  assign ahb.HADDR     = haddr_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HSIZE     = HSIZE_WORD;
  assign ahb.HBURST    = HBURST_SINGLE;
  assign ahb.HPROT     = HPROT_DATA;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HWDATA    = hwdata_q;
  assign tx_en         = tx_en_q;
  assign tx_data       = tx_data_q;

  // Writes and errors answer with one byte; successful reads with four.
  assign last_byte = is_write_q || err_q || (byte_cnt_q == 2'd3);

  always_comb begin
    state_d    = state_q;
    tx_phase_d = tx_phase_q;
    is_write_d = is_write_q;
    err_d      = err_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    tmo_d      = tmo_q;
    htrans_d   = HTRANS_IDLE;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    tx_en_d    = 1'b0;
    tx_data_d  = tx_data_q;

    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
          state_d    = StAddr;
          is_write_d = (rx_data == CMD_WRITE);
          byte_cnt_d = 2'd0;
          tmo_d      = '0;
        end
      end

      StAddr, StData: begin
        if (rx_valid) begin
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Little-endian: shift in from the top so the first byte lands in [7:0].
          if (state_q == StAddr) begin
            addr_d = {rx_data, addr_q[31:8]};
          end else begin
            wdata_d = {rx_data, wdata_q[31:8]};
          end
          if (byte_cnt_q == 2'd3) begin
            if (state_q == StAddr && is_write_q) begin
              state_d = StData;
            end else begin
              state_d  = StBusA;
              htrans_d = HTRANS_NONSEQ;
              haddr_d  = {addr_d[31:2], 2'b00};
              hwrite_d = is_write_q;
            end
          end
        end else if (tmo_q == TimeoutMax) begin
          state_d    = StIdle;
          byte_cnt_d = 2'd0;
        end else begin
          tmo_d = tmo_q + TimeoutWidth'(1);
        end
      end

      StBusA: begin
        htrans_d = HTRANS_NONSEQ;
        if (ahb.HREADY) begin
          htrans_d = HTRANS_IDLE;
          state_d  = StBusD;
          if (is_write_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      StBusD: begin
        if (ahb.HREADY) begin
          err_d      = ahb.HRESP;
          state_d    = StResp;
          byte_cnt_d = 2'd0;
          tx_phase_d = TxSend;
          tx_en_d    = 1'b1;
          if (!is_write_q) begin
            rdata_d = ahb.HRDATA;
          end
          if (ahb.HRESP) begin
            tx_data_d = ACK_ERR;
          end else if (is_write_q) begin
            tx_data_d = ACK_OK;
          end else begin
            tx_data_d = ahb.HRDATA[7:0];
          end
        end
      end

      StResp: begin
        unique case (tx_phase_q)
          TxSend: tx_phase_d = TxGap;
          // tx_busy may lag tx_en by one cycle, so skip a cycle before trusting it.
          TxGap:  tx_phase_d = TxWait;
          TxWait: begin
            if (!tx_busy) begin
              if (last_byte) begin
                state_d    = StIdle;
                byte_cnt_d = 2'd0;
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                tx_en_d    = 1'b1;
                tx_data_d  = rdata_q[{byte_cnt_d, 3'b000} +: 8];
                tx_phase_d = TxSend;
              end
            end
          end
          default: tx_phase_d = TxSend;
        endcase
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      tx_phase_q <= TxSend;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      byte_cnt_q <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tmo_q      <= '0;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_phase_q <= tx_phase_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      tmo_q      <= tmo_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_ahblite_uart_master.sv
// Directed self-checking bench for ahblite_uart_master: a UART transmitter model,
// an AHB-Lite slave model with programmable wait states / error, and one task per
// scenario with inline comparisons.
module tb_ahblite_uart_master;

  localparam int unsigned TIMEOUT = 16;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy;

  ahblite_uart_master_if ahb_bus();

  ahblite_uart_master #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_en   (tx_en),
    .tx_busy (tx_busy),
    .ahb     (ahb_bus)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // UART transmitter model: busy for 3 cycles starting the cycle after tx_en.
  int         busy_cnt = 0;
  int         busy_viol = 0;
  logic [7:0] tx_q[$];
  assign tx_busy = (busy_cnt != 0);

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      busy_cnt <= 0;
    end else if (tx_en) begin
      tx_q.push_back(tx_data);
      if (tx_busy) busy_viol <= busy_viol + 1;
      busy_cnt <= 3;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // AHB-Lite slave model.
  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          wcnt = 0;
  logic        dph = 1'b0;
  int          xfer_cnt = 0;
  int          nonseq_cycles = 0;
  logic [31:0] cap_addr = 32'h0;
  logic        cap_write = 1'b0;
  logic [31:0] cap_wdata = 32'h0;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dph            <= 1'b0;
      wcnt           <= 0;
      ahb_bus.HREADY <= 1'b1;
      ahb_bus.HRESP  <= 1'b0;
      ahb_bus.HRDATA <= 32'h0;
    end else begin
      if (ahb_bus.HTRANS == 2'b10) nonseq_cycles <= nonseq_cycles + 1;
      if (dph && ahb_bus.HREADY) begin
        dph       <= 1'b0;
        cap_wdata <= ahb_bus.HWDATA;
      end
      if (ahb_bus.HTRANS == 2'b10 && ahb_bus.HREADY) begin
        xfer_cnt  <= xfer_cnt + 1;
        cap_addr  <= ahb_bus.HADDR;
        cap_write <= ahb_bus.HWRITE;
        dph       <= 1'b1;
        if (slv_wait == 0) begin
          ahb_bus.HREADY <= 1'b1;
          ahb_bus.HRESP  <= slv_err;
          ahb_bus.HRDATA <= slv_rdata;
        end else begin
          ahb_bus.HREADY <= 1'b0;
          ahb_bus.HRESP  <= slv_err && (slv_wait == 1);
          ahb_bus.HRDATA <= 32'h0;
          wcnt           <= slv_wait;
        end
      end else if (dph && !ahb_bus.HREADY) begin
        if (wcnt == 1) begin
          ahb_bus.HREADY <= 1'b1;
          ahb_bus.HRESP  <= slv_err;
          ahb_bus.HRDATA <= slv_rdata;
          wcnt           <= 0;
        end else begin
          ahb_bus.HRESP <= slv_err && (wcnt == 2);
          wcnt          <= wcnt - 1;
        end
      end else begin
        ahb_bus.HREADY <= 1'b1;
        ahb_bus.HRESP  <= 1'b0;
        ahb_bus.HRDATA <= 32'h0;
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) step();
    checks++;
    if (tx_q.size() < n) begin
      errors++;
      $display("FAIL wait_tx got %0d bytes want %0d", tx_q.size(), n);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (2) step();
    checks++;
    if (ahb_bus.HTRANS !== 2'b00) begin
      errors++; $display("FAIL rst_htrans got %h want 00", ahb_bus.HTRANS);
    end
    checks++;
    if (ahb_bus.HADDR !== 32'h0) begin
      errors++; $display("FAIL rst_haddr got %h want 0", ahb_bus.HADDR);
    end
    checks++;
    if (ahb_bus.HWRITE !== 1'b0 || ahb_bus.HWDATA !== 32'h0) begin
      errors++; $display("FAIL rst_hwrite_hwdata got %b/%h want 0/0", ahb_bus.HWRITE, ahb_bus.HWDATA);
    end
    checks++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL rst_tx got %b/%h want 0/00", tx_en, tx_data);
    end
    checks++;
    if (ahb_bus.HSIZE !== 3'b010 || ahb_bus.HBURST !== 3'b000 || ahb_bus.HPROT !== 4'b0011
        || ahb_bus.HMASTLOCK !== 1'b0) begin
      errors++;
      $display("FAIL const_ctrl got %b %b %b %b want 010 000 0011 0", ahb_bus.HSIZE,
               ahb_bus.HBURST, ahb_bus.HPROT, ahb_bus.HMASTLOCK);
    end
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_write();
    int x0, n0, lat;
    tx_q.delete();
    x0 = xfer_cnt; n0 = nonseq_cycles;
    slv_wait = 0; slv_err = 1'b0;
    send_write(32'h2000_1000, 32'h1234_5678);
    checks++;
    if (ahb_bus.HTRANS !== 2'b10 || ahb_bus.HADDR !== 32'h2000_1000 || ahb_bus.HWRITE !== 1'b1) begin
      errors++;
      $display("FAIL wr_addr_phase got %h %h %b want 10 20001000 1", ahb_bus.HTRANS,
               ahb_bus.HADDR, ahb_bus.HWRITE);
    end
    lat = 1;
    while (!tx_en && lat < 50) begin step(); lat++; end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL wr_latency got %0d want 3", lat);
    end
    wait_tx(1, 100);
    repeat (12) step();
    checks++;
    if (xfer_cnt - x0 != 1 || nonseq_cycles - n0 != 1) begin
      errors++;
      $display("FAIL wr_xfers got %0d/%0d want 1/1", xfer_cnt - x0, nonseq_cycles - n0);
    end
    checks++;
    if (cap_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL wr_hwdata got %h want 12345678", cap_wdata);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
      errors++;
      $display("FAIL wr_ack got %0d bytes first %h want 1 byte 4b", tx_q.size(),
               (tx_q.size() > 0) ? tx_q[0] : 8'h00);
    end
  endtask

  task automatic test_read_wait();
    logic [7:0] exp_b[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int lat;
    tx_q.delete();
    busy_viol = 0;
    slv_wait = 2; slv_err = 1'b0; slv_rdata = 32'hDEAD_BEEF;
    send_read(32'h0000_0004);
    lat = 1;
    while (!tx_en && lat < 50) begin step(); lat++; end
    checks++;
    if (lat != 5) begin
      errors++; $display("FAIL rd_latency got %0d want 5", lat);
    end
    wait_tx(4, 400);
    repeat (12) step();
    checks++;
    if (cap_addr !== 32'h4 || cap_write !== 1'b0) begin
      errors++; $display("FAIL rd_addr got %h/%b want 00000004/0", cap_addr, cap_write);
    end
    checks++;
    if (tx_q.size() != 4) begin
      errors++; $display("FAIL rd_count got %0d want 4", tx_q.size());
    end
    for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL rd_byte%0d got %h want %h", i, tx_q[i], exp_b[i]);
      end
    end
    checks++;
    if (busy_viol != 0) begin
      errors++; $display("FAIL rd_tx_while_busy got %0d want 0", busy_viol);
    end
  endtask

  task automatic test_error();
    tx_q.delete();
    slv_wait = 1; slv_err = 1'b1;
    send_write(32'h0000_0008, 32'h4433_2211);
    wait_tx(1, 100);
    repeat (20) step();
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h45) begin
      errors++;
      $display("FAIL err_ack got %0d bytes first %h want 1 byte 45", tx_q.size(),
               (tx_q.size() > 0) ? tx_q[0] : 8'h00);
    end
    checks++;
    if (cap_addr !== 32'h8 || cap_write !== 1'b1) begin
      errors++; $display("FAIL err_addr got %h/%b want 00000008/1", cap_addr, cap_write);
    end
    slv_err = 1'b0; slv_wait = 0;
  endtask

  task automatic test_garbage_timeout();
    logic [7:0] exp_b[4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    int x0, n0;
    tx_q.delete();
    x0 = xfer_cnt; n0 = nonseq_cycles;
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (5) step();
    checks++;
    if (xfer_cnt != x0 || nonseq_cycles != n0) begin
      errors++; $display("FAIL garbage_bus got %0d transfers want 0", xfer_cnt - x0);
    end
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TIMEOUT + 10) step();
    checks++;
    if (xfer_cnt != x0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_quiet got %0d transfers %0d tx want 0 0", xfer_cnt - x0, tx_q.size());
    end
    slv_wait = 0; slv_rdata = 32'hCAFE_F00D;
    send_read(32'h0000_0004);
    wait_tx(4, 200);
    repeat (12) step();
    checks++;
    if (cap_addr !== 32'h4 || xfer_cnt - x0 != 1) begin
      errors++; $display("FAIL post_timeout_addr got %h (%0d xfers) want 00000004 (1)",
                         cap_addr, xfer_cnt - x0);
    end
    for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL post_timeout_byte%0d got %h want %h", i, tx_q[i], exp_b[i]);
      end
    end
    // Gaps just under the timeout must not break the frame.
    tx_q.delete();
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) begin
      repeat (TIMEOUT - 4) step();
      send_byte((i == 0) ? 8'h0C : 8'h00);
    end
    wait_tx(4, 200);
    repeat (12) step();
    checks++;
    if (cap_addr !== 32'hC || xfer_cnt - x0 != 2) begin
      errors++; $display("FAIL slow_frame_addr got %h (%0d xfers) want 0000000c (2)",
                         cap_addr, xfer_cnt - x0);
    end
  endtask

  task automatic test_misaligned();
    tx_q.delete();
    slv_wait = 0; slv_rdata = 32'h0102_0304;
    send_read(32'h0000_0003);
    checks++;
    if (ahb_bus.HTRANS !== 2'b10 || ahb_bus.HADDR !== 32'h0) begin
      errors++; $display("FAIL misaligned_haddr got %h/%h want 10/00000000",
                         ahb_bus.HTRANS, ahb_bus.HADDR);
    end
    wait_tx(4, 200);
    repeat (12) step();
    checks++;
    if (tx_q.size() != 4 || tx_q[0] !== 8'h04) begin
      errors++; $display("FAIL misaligned_resp got %0d bytes want 4 starting 04", tx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    tx_q.delete();
    slv_wait = 30; slv_err = 1'b0;
    send_read(32'h0000_0010);
    step();
    checks++;
    if (ahb_bus.HREADY !== 1'b0 || ahb_bus.HADDR !== 32'h10) begin
      errors++; $display("FAIL mid_setup got hready %b haddr %h want 0/00000010",
                         ahb_bus.HREADY, ahb_bus.HADDR);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (ahb_bus.HTRANS !== 2'b00 || tx_en !== 1'b0 || ahb_bus.HADDR !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got htrans %h tx_en %b haddr %h want 00 0 00000000",
               ahb_bus.HTRANS, tx_en, ahb_bus.HADDR);
    end
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    slv_wait = 0;
    step();
    tx_q.delete();
    send_write(32'h0000_0030, 32'hA1B2_C3D4);
    wait_tx(1, 100);
    repeat (12) step();
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h4B || cap_addr !== 32'h30 || cap_wdata !== 32'hA1B2_C3D4) begin
      errors++;
      $display("FAIL after_reset got %0d tx addr %h wdata %h want 1 tx(4b) 00000030 a1b2c3d4",
               tx_q.size(), cap_addr, cap_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_garbage_timeout();
    test_misaligned();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule

// File: doc/ahblite_uart_master.md
# ahblite_uart_master

UART-driven AHB-Lite bus master for boot loading and debug: parses command frames from the UART receive path, performs single-word AHB-Lite reads and writes, and returns responses on the UART transmit path. It sits beside the processor as a second bus initiator, the initiator end of the bus its slaves respond to, and reaches RAMCODE, RAMDATA and peripherals through the bus multiplexer. Arbitration between the two masters is outside this block.

## Interface
- TIMEOUT_CYCLES, 1_000_000: idle cycles between frame bytes before the parser abandons a partial frame.
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  reset; asynchronous and active-low.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_data  out  8  byte to transmit; held stable from tx_en until the next tx_en.
- tx_en  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy; goes high no later than the cycle after tx_en and stays high until the byte is sent.
- HADDR  out  32  address; bits [1:0] always 0.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HSIZE  out  3  constant 010 (word).
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4  constant 0011.
- HMASTLOCK  out  1  constant 0.
- HWRITE  out  1  transfer direction.
- HWDATA  out  32  write data, driven during the data phase.
- HRDATA  in  32  read data.
- HREADY  in  1  bus ready.
- HRESP  in  1  error response.

## Operation
- **Frame format.** Command byte, then 4 address bytes, little-endian. A write frame (0xA5) adds 4 data bytes, little-endian. A read frame is 0x5A plus the address bytes only.
- **IDLE.** Any other byte is discarded and the parser stays in IDLE.
- **States.**
  - IDLE -> ADDR on a valid command byte.
  - ADDR collects 4 bytes, then goes to DATA (write) or BUS_A (read).
  - DATA collects 4 bytes, then goes to BUS_A.
  - BUS_A -> BUS_D -> RESP -> IDLE.
- **Address.** The assembled address has bits [1:0] forced to 0.
- **BUS_A.** Drives HTRANS=NONSEQ, HADDR and HWRITE. It holds these until an edge where HREADY=1, then moves to BUS_D.
- **BUS_D.**
  - Drives HTRANS=IDLE and, for a write, HWDATA.
  - At the edge where HREADY=1, it latches HRESP as the error flag.
  - For a read, it also latches HRDATA at that same edge.
- **RESP.**
  - Write: sends 0x4B on success, 0x45 on error.
  - Read: sends the 4 data bytes, little-endian, or the single byte 0x45 on error.
- **Byte transmit sequence.** Raise tx_en for one cycle with tx_data, wait one cycle, then wait for tx_busy=0 before the next byte or before leaving RESP.
- **Dropped bytes.** rx_valid in BUS_A, BUS_D or RESP is ignored and the byte is lost.
- **Timeout.** In ADDR or DATA, a counter resets on each rx_valid. When it reaches TIMEOUT_CYCLES, the state returns to IDLE and the partial frame is discarded; no response is sent. The counter width is clog2(TIMEOUT_CYCLES+1).
- **Reset.** Reset mid-operation aborts immediately: the current bus transfer is dropped and any transmit in progress is cut off.

## Timing
- **Reset values.**
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0.
  - tx_en=0, tx_data=0.
  - State IDLE, byte counters 0.
- **Outputs.** All outputs are registered; none depend combinationally on inputs.
- **Address phase.** Begins the cycle after the last frame byte is sampled. Minimum length 1 cycle; extended while HREADY=0.
- **Data phase.** Minimum length 1 cycle; extended while HREADY=0.
- **First response byte.** tx_en asserts on the cycle after the data-phase-completing edge.
- **Zero-wait best case.** From the final rx_valid to tx_en is 3 cycles.
- **HRESP handling.**
  - HRESP is sampled only at edges where HREADY=1 in BUS_D.
  - In the first cycle of a two-cycle error (HREADY=0), the block keeps waiting.
- **HTRANS never NONSEQ outside BUS_A.** The block issues no back-to-back transfers.

## Structure
- **Shared package.** Holds:
  - CMD_WRITE=8'hA5, CMD_READ=8'h5A, ACK_OK=8'h4B, ACK_ERR=8'h45;
  - the state encoding (IDLE, ADDR, DATA, BUS_A, BUS_D, RESP);
  - the HTRANS_IDLE/HTRANS_NONSEQ constants.
- **Single module.** No sub-module; the byte assembler, timeout counter and response serializer are inline.

## Test plan
- **Write, zero-wait slave.** Rx A5 00 10 00 20 78 56 34 12 -> one NONSEQ write, HADDR=0x20001000, HWDATA=0x12345678, then tx 0x4B.
- **Read with 2 wait states.** Rx 5A 04 00 00 00, slave returns 0xDEADBEEF after 2 HREADY=0 cycles -> tx EF BE AD DE, each tx_en only after tx_busy falls.
- **Error response.** Write frame; slave gives two-cycle HRESP=1 (HREADY 0 then 1) -> tx 0x45 only, then back in IDLE.
- **Garbage and timeout.** Rx 0x00 0xFF -> no bus activity. Rx A5 01 02 then silence for TIMEOUT_CYCLES -> IDLE, no tx. A following valid read completes normally.
- **Misaligned address.** Read with address bytes 03 00 00 00 -> HADDR=0x00000000.
- **Reset mid-transfer.** Deassert HRESETn during BUS_D with HREADY=0 -> HTRANS=00 and tx_en=0 immediately. After release, a new frame is accepted.
